sqrt_iter_param: RTL and testbench

Parametrised iterative integer square root: floor(sqrt(a)) for an unsigned operand of DATA_W bits, one result bit per clock.
- Successor to the fixed 16-bit sqrt unit; generalised in width, with a done pulse, zero-operand fast path and optional remainder output.
- Subtraction is done by the shared external summator through dedicated operand/result ports, so the block can share the multiplier/adder datapath with other arithmetic units.

---
 rtl/sqrt_pkg.sv | 20 ++
 rtl/sqrt_step.sv | 30 +++
 rtl/sqrt_iter_param.sv | 116 +++++++++++
 tb/tb_sqrt_iter_param.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM state encoding and width helpers for sqrt_iter_param.
// No ports; imported by sqrt_step and sqrt_iter_param.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  // One root bit is produced per iteration.
  function automatic int root_w(input int data_w);
    return data_w / 2;
  endfunction

  function automatic bit data_w_ok(input int data_w);
    return (data_w % 2 == 0) && (data_w >= 4);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational restoring-sqrt iteration.
// In: x, y, m, sum_res (x - b from the summator). Out: b, x_nxt, y_nxt, m_nxt.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] m,
  input  logic [DATA_W-1:0] sum_res,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] x_nxt,
  output logic [DATA_W-1:0] y_nxt,
  output logic [DATA_W-1:0] m_nxt
);

  always_comb begin
    b     = y | m;
    x_nxt = x;
    y_nxt = y >> 1;
    m_nxt = m >> 2;
    // Compare is local; the summator only supplies the difference.
    if (x >= b) begin
      x_nxt = sum_res;
      y_nxt = (y >> 1) | m;
    end
  end

endmodule

// File: rtl/sqrt_iter_param.sv
// sqrt_iter_param: iterative floor(sqrt(a_bi)), one root bit per clock,
// subtraction via external summator. Optional rem_bo with `SQRT_REM_EN.
// Ports: clk_i, rst_i (async high), start_i, a_bi, ready_o, busy_o,
// done_o, y_bo, [rem_bo], summator_a_o, summator_b_o, summator_res_i.
module sqrt_iter_param
  import sqrt_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int ROOT_W = root_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_bi,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ROOT_W-1:0] y_bo,
`ifdef SQRT_REM_EN
  output logic [ROOT_W:0]   rem_bo,
`endif
  output logic [DATA_W:0]   summator_a_o,
  output logic [DATA_W:0]   summator_b_o,
  input  logic [DATA_W:0]   summator_res_i
);

  if (!data_w_ok(DATA_W)) begin : g_bad_width
    $error("sqrt_iter_param: DATA_W must be even and >= 4");
  end

  localparam logic [DATA_W-1:0] M_INIT =
    {2'b01, {(DATA_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] M_LAST =
    {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DATA_W-1:0] x, y, m;
  logic [DATA_W-1:0] b, x_nxt, y_nxt, m_nxt;

  // Carry-out of the summator is not needed: x >= b is checked locally.
  logic unused_carry;
  assign unused_carry = summator_res_i[DATA_W];

  sqrt_step #(.DATA_W(DATA_W)) u_step (
    .x       (x),
    .y       (y),
    .m       (m),
    .sum_res (summator_res_i[DATA_W-1:0]),
    .b       (b),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt),
    .m_nxt   (m_nxt)
  );

  assign summator_a_o = {1'b0, x};
  assign summator_b_o = -{1'b0, b};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      m       <= '0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      y_bo    <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            x       <= a_bi;
            y       <= '0;
            m       <= M_INIT;
            ready_o <= 1'b0;
            if (a_bi == '0) begin
              state <= DONE;
            end else begin
              state  <= WORK;
              busy_o <= 1'b1;
            end
          end
        end
        WORK: begin
          x <= x_nxt;
          y <= y_nxt;
          m <= m_nxt;
          if (m == M_LAST) begin
            state  <= DONE;
            busy_o <= 1'b0;
          end
        end
        DONE: begin
          y_bo    <= y[ROOT_W-1:0];
          done_o  <= 1'b1;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SQRT_REM_EN
  // Remainder is at most 2*root, so ROOT_W+1 bits of x suffice.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_bo <= '0;
    end else if (state == DONE) begin
      rem_bo <= x[ROOT_W:0];
    end
  end
`endif

endmodule

// File: tb/tb_sqrt_iter_param.sv
// tb_sqrt_iter_param: directed and random checks of sqrt_iter_param
// at DATA_W = 8, 16 and 32 with a behavioural summator.
module tb_sqrt_iter_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // ---------------- DATA_W = 16 ----------------
  logic        st16;
  logic [15:0] a16;
  logic        rdy16, bsy16, dn16;
  logic [7:0]  y16;
  logic [16:0] sa16, sb16, sr16;
`ifdef SQRT_REM_EN
  logic [8:0]  r16;
`endif
  assign sr16 = sa16 + sb16;

  sqrt_iter_param #(.DATA_W(16)) u16 (
    .clk_i(clk), .rst_i(rst), .start_i(st16), .a_bi(a16),
    .ready_o(rdy16), .busy_o(bsy16), .done_o(dn16), .y_bo(y16),
`ifdef SQRT_REM_EN
    .rem_bo(r16),
`endif
    .summator_a_o(sa16), .summator_b_o(sb16), .summator_res_i(sr16)
  );

  // ---------------- DATA_W = 8 ----------------
  logic        st8;
  logic [7:0]  a8;
  logic        rdy8, bsy8, dn8;
  logic [3:0]  y8;
  logic [8:0]  sa8, sb8, sr8;
`ifdef SQRT_REM_EN
  logic [4:0]  r8;
`endif
  assign sr8 = sa8 + sb8;

  sqrt_iter_param #(.DATA_W(8)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(st8), .a_bi(a8),
    .ready_o(rdy8), .busy_o(bsy8), .done_o(dn8), .y_bo(y8),
`ifdef SQRT_REM_EN
    .rem_bo(r8),
`endif
    .summator_a_o(sa8), .summator_b_o(sb8), .summator_res_i(sr8)
  );

  // ---------------- DATA_W = 32 ----------------
  logic        st32;
  logic [31:0] a32;
  logic        rdy32, bsy32, dn32;
  logic [15:0] y32;
  logic [32:0] sa32, sb32, sr32;
`ifdef SQRT_REM_EN
  logic [16:0] r32;
`endif
  assign sr32 = sa32 + sb32;

  sqrt_iter_param #(.DATA_W(32)) u32 (
    .clk_i(clk), .rst_i(rst), .start_i(st32), .a_bi(a32),
    .ready_o(rdy32), .busy_o(bsy32), .done_o(dn32), .y_bo(y32),
`ifdef SQRT_REM_EN
    .rem_bo(r32),
`endif
    .summator_a_o(sa32), .summator_b_o(sb32), .summator_res_i(sr32)
  );

  // Reference root by binary search (lo^2 <= a < hi^2).
  function automatic longint unsigned isqrt(input longint unsigned a);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'h1_0000_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= a) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // One operation per task call; lat counts edges from accept to done_o.
  task automatic run16(input logic [15:0] a, output logic [7:0] y,
                       output logic [8:0] rem, output int lat);
    @(negedge clk);
    st16 = 1'b1;
    a16  = a;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    a16  = 16'($urandom);
    lat  = 0;
    while (!dn16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y   = y16;
    rem = '0;
`ifdef SQRT_REM_EN
    rem = r16;
`endif
  endtask

  task automatic run8(input logic [7:0] a, output logic [3:0] y,
                      output logic [4:0] rem, output int lat);
    @(negedge clk);
    st8 = 1'b1;
    a8  = a;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    a8  = 8'($urandom);
    lat = 0;
    while (!dn8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y   = y8;
    rem = '0;
`ifdef SQRT_REM_EN
    rem = r8;
`endif
  endtask

  task automatic run32(input logic [31:0] a, output logic [15:0] y,
                       output logic [16:0] rem, output int lat);
    @(negedge clk);
    st32 = 1'b1;
    a32  = a;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    a32  = $urandom;
    lat  = 0;
    while (!dn32 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y   = y32;
    rem = '0;
`ifdef SQRT_REM_EN
    rem = r32;
`endif
  endtask

  task automatic test_reset;
    n_run++;
    if (rdy16 !== 1'b1 || bsy16 !== 1'b0 || dn16 !== 1'b0 ||
        y16 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b bsy=%b dn=%b y=%0d, need 1 0 0 0",
               rdy16, bsy16, dn16, y16);
    end
    n_run++;
    if (sa16 !== 17'd0 || sb16 !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_summator: a=%h b=%h, need 0 0", sa16, sb16);
    end
  endtask

  task automatic test_directed16;
    logic [15:0] va[10];
    logic [7:0]  vy[10];
    logic [8:0]  vr[10];
    int          vl[10];
    logic [7:0]  y;
    logic [8:0]  rem;
    int          lat;
    va = '{16'd225, 16'd65535, 16'd17, 16'd2, 16'd0,
           16'd1, 16'd3, 16'd16384, 16'd65024, 16'd4};
    vy = '{8'd15, 8'd255, 8'd4, 8'd1, 8'd0,
           8'd1, 8'd1, 8'd128, 8'd254, 8'd2};
    vr = '{9'd0, 9'd510, 9'd1, 9'd1, 9'd0,
           9'd0, 9'd2, 9'd0, 9'd508, 9'd0};
    vl = '{9, 9, 9, 9, 1, 9, 9, 9, 9, 9};
    for (int i = 0; i < 10; i++) begin
      run16(va[i], y, rem, lat);
      n_run++;
      if (lat !== vl[i]) begin
        n_fail++;
        $display("FAIL lat16 a=%0d: got %0d, need %0d", va[i], lat, vl[i]);
      end
      n_run++;
      if (y !== vy[i]) begin
        n_fail++;
        $display("FAIL root16 a=%0d: got %0d, need %0d", va[i], y, vy[i]);
      end
`ifdef SQRT_REM_EN
      n_run++;
      if (rem !== vr[i]) begin
        n_fail++;
        $display("FAIL rem16 a=%0d: got %0d, need %0d", va[i], rem, vr[i]);
      end
`endif
    end
  endtask

  task automatic test_summator;
    int k;
    @(negedge clk);
    st16 = 1'b1;
    a16  = 16'd225;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    // First iteration: x = a, y = 0, m = 1<<14, so b = 0x4000.
    n_run++;
    if (sa16 !== 17'd225 || sb16 !== 17'h1_C000) begin
      n_fail++;
      $display("FAIL summator_first: a=%h b=%h, need 000e1 1c000",
               sa16, sb16);
    end
    n_run++;
    if (rdy16 !== 1'b0 || bsy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_flags: rdy=%b bsy=%b, need 0 1", rdy16, bsy16);
    end
    k = 0;
    while (!dn16 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_run++;
    if (k !== 9 || y16 !== 8'd15) begin
      n_fail++;
      $display("FAIL summator_run: lat=%0d y=%0d, need 9 15", k, y16);
    end
  endtask

  task automatic test_reset_mid_work;
    logic [7:0] y;
    logic [8:0] rem;
    int         lat;
    int         seen;
    run16(16'd17, y, rem, lat);
    @(negedge clk);
    st16 = 1'b1;
    a16  = 16'd225;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_run++;
    if (rdy16 !== 1'b1 || bsy16 !== 1'b0 || y16 !== 8'd0 ||
        dn16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b bsy=%b y=%0d dn=%b, need 1 0 0 0",
               rdy16, bsy16, y16, dn16);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (dn16) seen++;
    end
    n_run++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d pulses, need 0", seen);
    end
    run16(16'd225, y, rem, lat);
    n_run++;
    if (y !== 8'd15 || lat !== 9) begin
      n_fail++;
      $display("FAIL after_reset: y=%0d lat=%0d, need 15 9", y, lat);
    end
`ifdef SQRT_REM_EN
    n_run++;
    if (rem !== 9'd0) begin
      n_fail++;
      $display("FAIL after_reset_rem: got %0d, need 0", rem);
    end
`endif
  endtask

  // start_i held high; accepts happen at edges 0, 10, 20, 30.
  task automatic test_back_to_back;
    int         d_cyc[$];
    logic [7:0] d_y[$];
    longint unsigned ex;
    d_cyc.delete();
    d_y.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      st16 = 1'b1;
      a16  = 16'(1000 + 37 * c);
      @(posedge clk);
      #1;
      if (dn16) begin
        d_cyc.push_back(c);
        d_y.push_back(y16);
      end
    end
    st16 = 1'b0;
    n_run++;
    if (d_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, need 4", d_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ex = isqrt(longint'(1000 + 37 * 10 * i));
        n_run++;
        if (d_cyc[i] !== 10 * i + 9 || d_y[i] !== 8'(ex)) begin
          n_fail++;
          $display("FAIL b2b_%0d: edge=%0d y=%0d, need %0d %0d",
                   i, d_cyc[i], d_y[i], 10 * i + 9, ex);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random16;
    logic [15:0] a;
    logic [7:0]  y;
    logic [8:0]  rem;
    int          lat;
    longint unsigned yy, aa;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      if (i % 100 == 0) a = 16'(i / 100);
      run16(a, y, rem, lat);
      yy = longint'(y);
      aa = longint'(a);
      n_run++;
      if (!(yy * yy <= aa && (yy + 1) * (yy + 1) > aa) ||
          lat !== ((a == 0) ? 1 : 9)) begin
        n_fail++;
        $display("FAIL rand16 a=%0d: y=%0d lat=%0d", a, y, lat);
      end
`ifdef SQRT_REM_EN
      n_run++;
      if (longint'(rem) !== aa - yy * yy) begin
        n_fail++;
        $display("FAIL rand16_rem a=%0d: got %0d, need %0d",
                 a, rem, aa - yy * yy);
      end
`endif
    end
  endtask

  task automatic test_width8;
    logic [7:0] a;
    logic [3:0] y;
    logic [4:0] rem;
    int         lat;
    longint unsigned yy, aa;
    run8(8'd255, y, rem, lat);
    n_run++;
    if (y !== 4'd15 || lat !== 5) begin
      n_fail++;
      $display("FAIL w8_max: y=%0d lat=%0d, need 15 5", y, lat);
    end
`ifdef SQRT_REM_EN
    n_run++;
    if (rem !== 5'd30) begin
      n_fail++;
      $display("FAIL w8_max_rem: got %0d, need 30", rem);
    end
`endif
    for (int i = 0; i < 1000; i++) begin
      a = (i < 256) ? 8'(i) : 8'($urandom);
      run8(a, y, rem, lat);
      yy = longint'(y);
      aa = longint'(a);
      n_run++;
      if (!(yy * yy <= aa && (yy + 1) * (yy + 1) > aa) ||
          lat !== ((a == 0) ? 1 : 5)) begin
        n_fail++;
        $display("FAIL rand8 a=%0d: y=%0d lat=%0d", a, y, lat);
      end
`ifdef SQRT_REM_EN
      n_run++;
      if (longint'(rem) !== aa - yy * yy) begin
        n_fail++;
        $display("FAIL rand8_rem a=%0d: got %0d", a, rem);
      end
`endif
    end
  endtask

  task automatic test_width32;
    logic [31:0] a;
    logic [15:0] y;
    logic [16:0] rem;
    int          lat;
    longint unsigned yy, aa;
    run32(32'hFFFF_FFFF, y, rem, lat);
    n_run++;
    if (y !== 16'd65535 || lat !== 17) begin
      n_fail++;
      $display("FAIL w32_max: y=%0d lat=%0d, need 65535 17", y, lat);
    end
`ifdef SQRT_REM_EN
    n_run++;
    if (rem !== 17'd131070) begin
      n_fail++;
      $display("FAIL w32_max_rem: got %0d, need 131070", rem);
    end
`endif
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if (i % 4 == 1) a = a >> (i % 31);
      run32(a, y, rem, lat);
      yy = longint'(y);
      aa = longint'(a);
      n_run++;
      if (!(yy * yy <= aa && (yy + 1) * (yy + 1) > aa) ||
          lat !== ((a == 0) ? 1 : 17)) begin
        n_fail++;
        $display("FAIL rand32 a=%0d: y=%0d lat=%0d", a, y, lat);
      end
`ifdef SQRT_REM_EN
      n_run++;
      if (longint'(rem) !== aa - yy * yy) begin
        n_fail++;
        $display("FAIL rand32_rem a=%0d: got %0d", a, rem);
      end
`endif
    end
  endtask

  initial begin
    rst  = 1'b1;
    st16 = 1'b0;
    a16  = '0;
    st8  = 1'b0;
    a8   = '0;
    st32 = 1'b0;
    a32  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed16();
    test_summator();
    test_reset_mid_work();
    test_back_to_back();
    test_random16();
    test_width8();
    test_width32();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
